// File: rtl/data_memory_if.sv
// Load/store bus between the core (master) and the data memory (slave).
interface data_memory_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        stall;
  logic        done;
  logic        fault;

  modport master (
    output address, write_data, mem_read, mem_write, func3,
    input  read_data, stall, done, fault
  );

  modport slave (
    input  address, write_data, mem_read, mem_write, func3,
    output read_data, stall, done, fault
  );
endinterface

// File: rtl/data_memory.sv
// Multi-cycle RISC-V data memory: IDLE -> WAIT (WAIT_CYCLES) -> RESPOND.
// Byte/halfword/word loads and stores, little-endian, with misalignment and
// illegal-func3 faults. The core holds its inputs stable while stall is high.
module data_memory #(
  parameter int WORDS       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  data_memory_if.slave bus
);
  localparam int AW = $clog2(WORDS);
  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [WORDS];

  logic          req, is_store, bad, commit;
  logic [AW-1:0] idx;
  logic [1:0]    boff;
  logic [31:0]   word, load_val, store_word;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic          unused_addr;

  assign req         = bus.mem_read | bus.mem_write;
  assign is_store    = bus.mem_write;             // store wins if both are high
  assign idx         = bus.address[AW+1:2];       // upper bits ignored: address wraps
  assign boff        = bus.address[1:0];
  assign unused_addr = ^bus.address[31:AW+2];

  assign bus.stall     = ((state_q == IDLE) && req) || (state_q == WAIT);
  assign bus.done      = done_q;
  assign bus.fault     = fault_q;
  assign bus.read_data = rdata_q;

  // Decode access legality, extract the load value and merge the store lanes.
  always_comb begin
    bad = 1'b0;
    case (bus.func3[1:0])
      2'b01:   bad = bus.address[0];
      2'b10:   bad = |bus.address[1:0];
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
    if (is_store && bus.func3[2]) bad = 1'b1;
    if (!is_store && (bus.func3 == 3'b110)) bad = 1'b1;

    word = mem[idx];
    bsel = word[{boff, 3'b000} +: 8];
    hsel = word[{boff[1], 4'b0000} +: 16];
    case (bus.func3)
      3'b000:  load_val = {{24{bsel[7]}}, bsel};
      3'b001:  load_val = {{16{hsel[15]}}, hsel};
      3'b010:  load_val = word;
      3'b100:  load_val = {24'd0, bsel};
      3'b101:  load_val = {16'd0, hsel};
      default: load_val = 32'd0;
    endcase

    store_word = word;
    case (bus.func3[1:0])
      2'b00:   store_word[{boff, 3'b000} +: 8]     = bus.write_data[7:0];
      2'b01:   store_word[{boff[1], 4'b0000} +: 16] = bus.write_data[15:0];
      default: store_word = bus.write_data;
    endcase
  end

  // Next-state logic; the access commits on the edge that enters RESPOND.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    rdata_d = rdata_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESPOND;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      done_d  = 1'b1;
      fault_d = bad;
      if (bad)            rdata_d = 32'd0;
      else if (!is_store) rdata_d = load_val;
    end
  end

  // Control and response registers; reset discards any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array is not reset; a reset present at the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && is_store && !bad) mem[idx] <= store_word;
  end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter WORDS, default 1024, memory depth in 32-bit words; SHALL be a power of two, 16 to 65536.
REQ-002 Parameter WAIT_CYCLES, default 2, extra access wait states; SHALL be 0 to 15.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 address  input  32  byte address, driven by the ALU result.
REQ-006 write_data  input  32  store data; the low byte or halfword is used for narrow stores.
REQ-007 mem_read  input  1  load request.
REQ-008 mem_write  input  1  store request.
REQ-009 func3  input  3  access width and signedness, using the RISC-V funct3 encoding.
REQ-010 read_data  output  32  load result, extended to 32 bits.
REQ-011 stall  output  1  high while an access is outstanding; the core freezes its PC and holds all inputs stable while it is high.
REQ-012 done  output  1  one-cycle pulse that completes an access.
REQ-013 fault  output  1  qualifies done; high means a misaligned access or an illegal func3.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESPOND.
REQ-015 A request is mem_read or mem_write high; if both are high, the access SHALL be treated as a store and the load is ignored.
REQ-016 IDLE with a request SHALL assert stall combinationally in the same cycle.
REQ-017 From IDLE with a request, the next state SHALL be WAIT with the wait counter at WAIT_CYCLES-1; if WAIT_CYCLES=0, the next state SHALL be RESPOND.
REQ-018 In WAIT, stall SHALL be high; the counter decrements each cycle, and the FSM SHALL move to RESPOND on the edge where the counter is 0.
REQ-019 In RESPOND, stall SHALL be 0, done SHALL be 1 and read_data and fault SHALL be valid; the next state SHALL be IDLE unconditionally.
REQ-020 Latency: a request first seen in cycle 0 SHALL produce done in cycle WAIT_CYCLES+1; back-to-back requests SHALL have one IDLE cycle between them.
REQ-021 A store SHALL commit, and a load SHALL register read_data, on the edge that enters RESPOND, using the held inputs.
REQ-022 The word index SHALL be address[log2(WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo WORDS*4.
REQ-023 Loads: 000 lb sign-extends a byte, 001 lh sign-extends a halfword, 010 lw returns the word, 100 lbu zero-extends a byte, 101 lhu zero-extends a halfword.
REQ-024 Loads SHALL select the byte lane with address[1:0] and the halfword lane with address[1].
REQ-025 Stores: 000 sb writes one byte lane, 001 sh writes one halfword lane, 010 sw writes the full word; unselected lanes SHALL be unchanged.
REQ-026 A fault SHALL occur for halfword access with address[0]=1, word access with address[1:0]!=0, load func3 of 011, 110 or 111, or store func3 other than 000, 001 or 010.
REQ-027 On a fault, no memory write SHALL occur, read_data SHALL be 0 and fault SHALL be 1 during RESPOND; the full latency still applies.
REQ-028 Outside RESPOND, done and fault SHALL be 0 and read_data SHALL hold its last value.
REQ-029 Memory SHALL be little-endian, with byte 0 at bits [7:0].

Reset
REQ-030 rst SHALL immediately force state IDLE, wait counter 0, done 0, fault 0 and read_data 0, with stall depending only on the request inputs.
REQ-031 Memory contents SHALL NOT be reset; they are X until first written.
REQ-032 Reset during WAIT SHALL discard the pending access, with no write and no done.
REQ-033 Reset asserted during the committing edge SHALL win, and no write SHALL occur.

Verification
REQ-034 WAIT_CYCLES=2: sw 0xDEADBEEF at 0x10, then lw at 0x10 -> stall high for cycles 0-2, done in cycle 3, read_data=0xDEADBEEF, fault=0.
REQ-035 After the word above: lb at 0x13 -> 0xFFFFFFDE; lbu at 0x13 -> 0x000000DE; lh at 0x12 -> 0xFFFFDEAD; lhu at 0x10 -> 0x0000BEEF.
REQ-036 sb 0x55 at 0x11, then lw at 0x10 -> 0xDEAD55EF; sh 0x1234 at 0x12, then lw at 0x10 -> 0x123455EF.
REQ-037 lw at 0x12, sh at 0x13 and load func3=011 -> fault=1 with done, read_data=0, and memory unchanged on read-back.
REQ-038 Reset in cycle 1 of sw 0xAAAAAAAA at 0x20, where 0x20 previously held 0x11111111 -> no done pulse, and a subsequent lw at 0x20 returns 0x11111111.
REQ-039 WAIT_CYCLES=0 with WORDS=1024: sw at 0x1000 -> done in cycle 1; lw at 0x0 -> returns the same word (wrap).
